cmp_unit_pipe: RTL

//  Parametrised, pipelined successor to the ALU compare unit. Each cycle it accepts one
//  op on a/b and returns it STAGES cycles later, tagged by out_valid. It keeps the legacy
//  EQ/GT/LT result codes and adds signed mode, MIN/MAX/ABSDIFF and a running min/max tracker.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_core.sv | 25 ++
 rtl/cmp_unit_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared function codes, legacy result codes and parameter checks for the pipelined compare unit.
package cmp_pkg;

  localparam logic [2:0] FN_NOP     = 3'd0;
  localparam logic [2:0] FN_EQ      = 3'd1;
  localparam logic [2:0] FN_GT      = 3'd2;
  localparam logic [2:0] FN_LT      = 3'd3;
  localparam logic [2:0] FN_MIN     = 3'd4;
  localparam logic [2:0] FN_MAX     = 3'd5;
  localparam logic [2:0] FN_ABSDIFF = 3'd6;
  localparam logic [2:0] FN_TRACK   = 3'd7;

  localparam int unsigned RES_EQ = 1;
  localparam int unsigned RES_GT = 2;
  localparam int unsigned RES_LT = 3;

  function automatic bit stages_legal(input int stages);
    return (stages >= 1) && (stages <= 4);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational compare of one operand pair: eq/gt/lt plus min, max and absolute difference.
module cmp_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] abs_diff
);

  assign eq = (a == b);
  assign gt = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
  assign lt = !eq && !gt;

  assign min_val = lt ? a : b;
  assign max_val = gt ? a : b;
  // Subtracting the smaller from the larger always fits in WIDTH unsigned bits.
  assign abs_diff = gt ? (a - b) : (b - a);

endmodule

// File: rtl/cmp_unit_pipe.sv
// Pipelined compare unit: one op per cycle, result after STAGES cycles, plus a min/max tracker.
module cmp_unit_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  input  logic             signed_mode,
  input  logic             track_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] cmp_out,
  output logic             cmp_flag,
  output logic [WIDTH-1:0] trk_min,
  output logic [WIDTH-1:0] trk_max,
  output logic [CNT_W-1:0] trk_cnt
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("cmp_unit_pipe: STAGES must be in 1..4");
  end

  logic             accept;
  logic             track_op;
  logic             op_eq, op_gt, op_lt;
  logic [WIDTH-1:0] op_min, op_max, op_abs;
  logic [WIDTH-1:0] trk_lo, trk_hi;
  logic [WIDTH-1:0] res;

  logic [CNT_W-1:0] cnt_base, cnt_upd;
  logic             trk_first;
  logic [WIDTH-1:0] trk_min_d, trk_max_d;
  logic [CNT_W-1:0] trk_cnt_d;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] dat_q [STAGES];

  assign accept   = enable & in_valid;
  assign track_op = accept && (func == FN_TRACK);

  cmp_core #(.WIDTH(WIDTH)) u_op_core (
    .a(a), .b(b), .signed_mode(signed_mode),
    .eq(op_eq), .gt(op_gt), .lt(op_lt),
    .min_val(op_min), .max_val(op_max), .abs_diff(op_abs)
  );

  // Tracker path: one compare against the stored minimum, one against the stored maximum.
  cmp_core #(.WIDTH(WIDTH)) u_trk_lo (
    .a(a), .b(trk_min), .signed_mode(signed_mode),
    .eq(), .gt(), .lt(),
    .min_val(trk_lo), .max_val(), .abs_diff()
  );

  cmp_core #(.WIDTH(WIDTH)) u_trk_hi (
    .a(a), .b(trk_max), .signed_mode(signed_mode),
    .eq(), .gt(), .lt(),
    .min_val(), .max_val(trk_hi), .abs_diff()
  );

  // A clear in the same cycle as a sample makes that sample the first one.
  assign cnt_base  = track_clr ? '0 : trk_cnt;
  assign trk_first = (cnt_base == '0);
  assign cnt_upd   = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    trk_min_d = track_clr ? '0 : trk_min;
    trk_max_d = track_clr ? '0 : trk_max;
    trk_cnt_d = cnt_base;
    if (track_op) begin
      trk_min_d = trk_first ? a : trk_lo;
      trk_max_d = trk_first ? a : trk_hi;
      trk_cnt_d = cnt_upd;
    end
  end

  always_comb begin
    res = '0;
    case (func)
      FN_EQ:      res = op_eq ? WIDTH'(RES_EQ) : '0;
      FN_GT:      res = op_gt ? WIDTH'(RES_GT) : '0;
      FN_LT:      res = op_lt ? WIDTH'(RES_LT) : '0;
      FN_MIN:     res = op_min;
      FN_MAX:     res = op_max;
      FN_ABSDIFF: res = op_abs;
      FN_TRACK:   res = WIDTH'(cnt_upd);
      default:    res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every stage samples pre-edge values.
    if (rst) begin
      trk_min <= '0;
      trk_max <= '0;
      trk_cnt <= '0;
    end else begin
      trk_min <= trk_min_d;
      trk_max <= trk_max_d;
      trk_cnt <= trk_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the data stages are reset too, so a flushed op can never leak onto cmp_out.
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      dat_q[0] <= accept ? res : '0;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign cmp_out   = dat_q[STAGES-1];
  assign cmp_flag  = vld_q[STAGES-1];

endmodule
